// File: rtl/sonic_vc_scheduler_if.sv
// Valid/ready handshake bundle between the two packet sources, the scheduler
// and the SoNIC virtual-channel multiplexer.
interface sonic_vc_scheduler_if;
    logic in0_valid;
    logic in1_valid;
    logic in0_startofpacket;
    logic in1_startofpacket;
    logic in0_endofpacket;
    logic in1_endofpacket;
    logic in0_ready;
    logic in1_ready;
    logic mux_in0_valid;
    logic mux_in1_valid;
    logic mux_in0_ready;
    logic mux_in1_ready;

    modport slave (
        input  in0_valid, in1_valid,
        input  in0_startofpacket, in1_startofpacket,
        input  in0_endofpacket, in1_endofpacket,
        input  mux_in0_ready, mux_in1_ready,
        output in0_ready, in1_ready,
        output mux_in0_valid, mux_in1_valid
    );

    modport master (
        output in0_valid, in1_valid,
        output in0_startofpacket, in1_startofpacket,
        output in0_endofpacket, in1_endofpacket,
        output mux_in0_ready, mux_in1_ready,
        input  in0_ready, in1_ready,
        input  mux_in0_valid, mux_in1_valid
    );
endinterface

// File: rtl/sonic_vc_scheduler.sv
// Packet-level weighted round-robin scheduler that gates the valid/ready
// handshake of two Avalon-ST sources into the SoNIC VC multiplexer.
module sonic_vc_scheduler #(
    parameter int WEIGHT_W = 4,
    parameter int WEIGHT0  = 1,
    parameter int WEIGHT1  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           chan_en,
    sonic_vc_scheduler_if.slave  bus,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 sop_err,
    output logic [CNT_W-1:0]     pkt_cnt0,
    output logic [CNT_W-1:0]     pkt_cnt1
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // A weight of zero would starve its channel, so it is promoted to one.
    localparam logic [WEIGHT_W-1:0] W0_EFF = (WEIGHT0 == 0) ? WEIGHT_W'(1) : WEIGHT_W'(WEIGHT0);
    localparam logic [WEIGHT_W-1:0] W1_EFF = (WEIGHT1 == 0) ? WEIGHT_W'(1) : WEIGHT_W'(WEIGHT1);

    state_t              state, state_next;
    logic [1:0]          grant_next;
    logic                ptr, ptr_next;
    logic [WEIGHT_W-1:0] cnt, cnt_next;
    logic                first, first_next;

    logic [1:0]          valid, mux_ready, sop, eop, req, accept;
    logic                other;
    logic [WEIGHT_W-1:0] wt_ptr;
    logic                acc_any, acc_sop, acc_eop;

    assign valid     = {bus.in1_valid, bus.in0_valid};
    assign mux_ready = {bus.mux_in1_ready, bus.mux_in0_ready};
    assign sop       = {bus.in1_startofpacket, bus.in0_startofpacket};
    assign eop       = {bus.in1_endofpacket, bus.in0_endofpacket};

    assign req     = valid & chan_en;
    assign accept  = valid & mux_ready & grant;
    assign acc_any = |accept;
    assign acc_sop = |(accept & sop);
    assign acc_eop = |(accept & eop);
    assign other   = ~ptr;
    assign wt_ptr  = ptr ? W1_EFF : W0_EFF;

    assign bus.mux_in0_valid = bus.in0_valid & grant[0];
    assign bus.mux_in1_valid = bus.in1_valid & grant[1];
    assign bus.in0_ready     = bus.mux_in0_ready & grant[0];
    assign bus.in1_ready     = bus.mux_in1_ready & grant[1];

    assign busy    = |grant;
    assign sop_err = first & acc_any & ~acc_sop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= 2'b00;
            ptr   <= 1'b0;
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
            first <= first_next;
        end
    end

    // The owner keeps its turn until its weight is spent; a spent owner is
    // still re-granted when the other channel has nothing to send.
    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        cnt_next   = cnt;
        first_next = first;
        case (state)
            IDLE: begin
                if (req[ptr] && (cnt < wt_ptr)) begin
                    state_next = GRANT;
                    grant_next = ptr ? 2'b10 : 2'b01;
                    first_next = 1'b1;
                end else if (req[other]) begin
                    state_next = GRANT;
                    grant_next = other ? 2'b10 : 2'b01;
                    ptr_next   = other;
                    cnt_next   = '0;
                    first_next = 1'b1;
                end else if (req[ptr]) begin
                    state_next = GRANT;
                    grant_next = ptr ? 2'b10 : 2'b01;
                    cnt_next   = '0;
                    first_next = 1'b1;
                end
            end
            GRANT: begin
                if (acc_any) begin
                    first_next = 1'b0;
                end
                if (acc_eop) begin
                    state_next = IDLE;
                    grant_next = 2'b00;
                    if (cnt != {WEIGHT_W{1'b1}}) begin
                        cnt_next = cnt + WEIGHT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (accept[0] && eop[0]) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (accept[1] && eop[1]) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/sonic_vc_scheduler.md
# sonic_vc_scheduler

Packet-level weighted round-robin scheduler for the two-input SoNIC virtual-channel multiplexer. It sits between two Avalon-ST packet sources and the multiplexer's in0/in1 ports and gates only the valid/ready handshake; data, error and empty signals are wired source-to-multiplexer and never pass through this block. At most one channel is presented to the multiplexer at a time, so the multiplexer's select always follows this block's grant. Per-channel enables and weights configure the share, and wrapping packet counters report the traffic on each channel.

## Interface
- WEIGHT_W, 4: width of the weight parameters and of the burst counter
- WEIGHT0, 1: packets channel 0 may send per turn; 0 is treated as 1
- WEIGHT1, 1: packets channel 1 may send per turn; 0 is treated as 1
- CNT_W, 16: width of the packet counters
- clk  in  1  clock; everything is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- chan_en  in  2  bit i enables channel i
- in0_valid, in1_valid  in  1  source valid
- in0_startofpacket, in1_startofpacket  in  1  source SOP
- in0_endofpacket, in1_endofpacket  in  1  source EOP
- in0_ready, in1_ready  out  1  ready back to the sources
- mux_in0_valid, mux_in1_valid  out  1  gated valid to the multiplexer
- mux_in0_ready, mux_in1_ready  in  1  ready from the multiplexer
- grant  out  2  one-hot active grant; 0 when idle
- busy  out  1  a grant is held
- sop_err  out  1  one-cycle pulse: first accepted beat of a grant lacked SOP
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets completed per channel; wraps

## Operation
- Beat accepted on channel i: in_i_valid & mux_in_i_ready & grant[i].
- Gating, combinational from the grant register:
  - mux_in_i_valid = in_i_valid & grant[i]
  - in_i_ready = mux_in_i_ready & grant[i]
  - A non-granted channel sees ready 0.
- Eligible channel: req[i] = in_i_valid & chan_en[i].
- Registered state:
  - state: IDLE or GRANT
  - ptr: 1 bit, the channel that owns the current turn
  - cnt: WEIGHT_W bits, packets completed in the current turn
  - first: set at grant, cleared on the first accepted beat
- IDLE arbitration, with W[i] = max(WEIGHT_i, 1):
  - req[ptr] & cnt<W[ptr]: grant ptr.
  - Otherwise, if req[~ptr]: grant ~ptr, ptr<=~ptr, cnt<=0.
  - Otherwise, if req[ptr] (weight used up, other channel has no request): grant ptr, cnt<=0. The scheduler is work-conserving.
  - Otherwise stay in IDLE.
- GRANT:
  - The grant is held until an EOP beat is accepted on the granted channel.
  - That EOP beat then causes: pkt_cnt_i += 1 (modulo 2^CNT_W), cnt += 1 (saturating at all ones), state <= IDLE, grant <= 0.
- Clearing chan_en does not abort a packet in flight. The channel is only excluded from later arbitration.
- Single-beat packets (SOP and EOP on the same beat) are legal.
- sop_err: pulses when first=1 and an accepted beat has SOP=0. The beat is still forwarded and the grant is not aborted.
- Reset, asynchronous:
  - state IDLE, grant 0, ptr 0, cnt 0, first 0, pkt counters 0.
  - Resulting outputs: busy 0, sop_err 0, all in_i_ready 0, all mux_in_i_valid 0.
  - A packet cut by reset is discarded from scheduler state.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N gives grant and mux_in_i_valid asserted in cycle N+1.
- One idle bubble cycle follows every EOP acceptance, even when the same channel continues.
- Best-case throughput for back-to-back packets is L/(L+1) for packets of L beats.
- Counters update on the edge that accepts the EOP beat, so they are visible the following cycle.
- If both channels request in the same IDLE cycle, the decision uses ptr and cnt. There is no fixed priority.
- A source dropping valid mid-packet keeps the grant. No timeout.
- Ready from the multiplexer may toggle freely. The grant is independent of back-pressure.

## Test plan
- Reset then idle, both channels enabled with no valid: grant=0, in0/in1_ready=0, pkt counters 0; after 4-beat packets are requested on ch0 then ch1, each completes and the counters read 1/1.
- WEIGHT0=2, WEIGHT1=1, both sources continuously offering 3-beat packets: grant order 0,0,1,0,0,1; after 9 packets pkt_cnt0=6, pkt_cnt1=3.
- Ch1 idle, ch0 streaming 1-beat packets with WEIGHT0=1: ch0 re-granted every second cycle; pkt_cnt0 increments every 2 cycles.
- chan_en cleared on ch0 at the 2nd beat of a 5-beat packet: the packet completes (5 beats accepted), then only ch1 is granted while ch0 valid stays high.
- mux_in0_ready held low for 3 cycles mid-packet: grant stays 01, in0_ready=0 for those cycles, no beat lost, EOP counted once.
- Granted ch1 whose first beat has SOP=0: sop_err high for exactly 1 cycle, beat forwarded; reset_n asserted mid-packet forces grant=0 asynchronously and clears pkt_cnt1 to 0.
